// File: rtl/frame_swap_pkg.sv
// frame_swap_pkg: shared constants and sizing helper for the frame-buffer swap controller
package frame_swap_pkg;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) r++;
        return r;
    endfunction

endpackage

// File: rtl/eof_edge_det.sv
// eof_edge_det: single-cycle end-of-frame edge detector with selectable polarity
module eof_edge_det
    import frame_swap_pkg::*;
#(
    parameter int EDGE_MODE = EDGE_RISE
) (
    input  logic p_clk,
    input  logic srst_p,
    input  logic eof,
    output logic eof_edge
);

    logic eof_d;

    // eof history runs regardless of enable so enabling mid-frame never fakes an edge
    always_ff @(posedge p_clk) eof_d <= srst_p ? 1'b0 : eof;

    assign eof_edge = (EDGE_MODE == EDGE_FALL) ? (~eof & eof_d) : (eof & ~eof_d);

endmodule

// File: rtl/frame_swap_ctrl_nbuf.sv
// frame_swap_ctrl_nbuf: rotates a ring of frame buffers between sensor writer and reader, dropping on overrun
module frame_swap_ctrl_nbuf
    import frame_swap_pkg::*;
#(
    parameter int NUM_BUF   = 2,
    parameter int EDGE_MODE = EDGE_RISE,
    parameter int DECIM     = 1,
    parameter int CNT_W     = 16,
    localparam int IDX_W    = (clog2(NUM_BUF) > 1) ? clog2(NUM_BUF) : 1
) (
    input  logic             p_clk,
    input  logic             srst_p,
    input  logic             enable,
    input  logic             eof,
    input  logic             rd_done,
    output logic [IDX_W-1:0] wr_sel,
    output logic [IDX_W-1:0] rd_sel,
    output logic             rd_valid,
    output logic             swap_p,
    output logic             drop_p,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int FC_W = clog2(NUM_BUF) + 1;
    localparam int DC_W = (clog2(DECIM) > 1) ? clog2(DECIM) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BUF - 1);
    localparam logic [FC_W-1:0]  FULL_MAX = FC_W'(NUM_BUF - 1);
    localparam logic [DC_W-1:0]  DEC_LAST = DC_W'(DECIM - 1);

    logic            eof_edge;
    logic            det, evt, rel, swap, drop;
    logic [DC_W-1:0] decim_cnt;
    logic [FC_W-1:0] full_cnt;

    eof_edge_det #(.EDGE_MODE(EDGE_MODE)) u_edge (
        .p_clk    (p_clk),
        .srst_p   (srst_p),
        .eof      (eof),
        .eof_edge (eof_edge)
    );

    // a release in the same cycle frees the oldest buffer, so a swap is allowed even when full
    always_comb begin
        det  = eof_edge & enable;
        evt  = det & (decim_cnt == DEC_LAST);
        rel  = rd_done & (full_cnt != '0);
        swap = evt & ((full_cnt < FULL_MAX) | rel);
        drop = evt & ~swap;
    end

    // decimator, ring pointers, occupancy and statistics
    always_ff @(posedge p_clk) begin
        if (srst_p) begin
            decim_cnt <= '0;
            frame_cnt <= '0;
            drop_cnt  <= '0;
            wr_sel    <= '0;
            rd_sel    <= '0;
            full_cnt  <= '0;
            swap_p    <= 1'b0;
            drop_p    <= 1'b0;
        end else begin
            decim_cnt <= det ? ((decim_cnt == DEC_LAST) ? '0 : decim_cnt + DC_W'(1)) : decim_cnt;
            frame_cnt <= frame_cnt + CNT_W'(det);
            drop_cnt  <= drop_cnt + CNT_W'(drop & ~&drop_cnt);
            wr_sel    <= swap ? ((wr_sel == IDX_LAST) ? '0 : wr_sel + IDX_W'(1)) : wr_sel;
            rd_sel    <= rel ? ((rd_sel == IDX_LAST) ? '0 : rd_sel + IDX_W'(1)) : rd_sel;
            full_cnt  <= full_cnt + FC_W'(swap) - FC_W'(rel);
            swap_p    <= swap;
            drop_p    <= drop;
        end
    end

    assign rd_valid = |full_cnt;

endmodule

// File: tb/tb_frame_swap_ctrl_nbuf.sv
// tb_frame_swap_ctrl_nbuf: scoreboard bench over three parameterisations of the swap controller
module tb_frame_swap_ctrl_nbuf;

    typedef struct packed {
        logic        swap;
        logic        drop;
        logic [1:0]  wr;
        logic [1:0]  rd;
        logic        rv;
        logic [15:0] fc;
        logic [15:0] dc;
    } exp_t;

    logic p_clk = 1'b0;
    logic srst_p = 1'b1;
    logic probe = 1'b0;
    logic fin = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    logic [2:0] enable = '1;
    logic [2:0] eof = '0;
    logic [2:0] rd_done = '0;

    logic        wr0, rd0;
    logic [1:0]  wr1, rd1, wr2, rd2;
    logic [2:0]  rv, sw, dp;
    logic [15:0] fc0, dc0, fc1, dc1, fc2, dc2;

    exp_t act [3];
    exp_t pq [3][$];
    int   sk [$];
    exp_t se [$];

    always #5 p_clk = ~p_clk;

    frame_swap_ctrl_nbuf u0 (
        .p_clk(p_clk), .srst_p(srst_p), .enable(enable[0]), .eof(eof[0]), .rd_done(rd_done[0]),
        .wr_sel(wr0), .rd_sel(rd0), .rd_valid(rv[0]), .swap_p(sw[0]), .drop_p(dp[0]),
        .frame_cnt(fc0), .drop_cnt(dc0)
    );

    frame_swap_ctrl_nbuf #(.NUM_BUF(3)) u1 (
        .p_clk(p_clk), .srst_p(srst_p), .enable(enable[1]), .eof(eof[1]), .rd_done(rd_done[1]),
        .wr_sel(wr1), .rd_sel(rd1), .rd_valid(rv[1]), .swap_p(sw[1]), .drop_p(dp[1]),
        .frame_cnt(fc1), .drop_cnt(dc1)
    );

    frame_swap_ctrl_nbuf #(.NUM_BUF(4), .EDGE_MODE(1), .DECIM(3)) u2 (
        .p_clk(p_clk), .srst_p(srst_p), .enable(enable[2]), .eof(eof[2]), .rd_done(rd_done[2]),
        .wr_sel(wr2), .rd_sel(rd2), .rd_valid(rv[2]), .swap_p(sw[2]), .drop_p(dp[2]),
        .frame_cnt(fc2), .drop_cnt(dc2)
    );

    assign act[0] = {sw[0], dp[0], 1'b0, wr0, 1'b0, rd0, rv[0], fc0, dc0};
    assign act[1] = {sw[1], dp[1], wr1, rd1, rv[1], fc1, dc1};
    assign act[2] = {sw[2], dp[2], wr2, rd2, rv[2], fc2, dc2};

    function automatic exp_t mk(input int s, input int d, input int w, input int r, input int v,
                                input int f, input int c);
        return {1'(s), 1'(d), 2'(w), 2'(r), 1'(v), 16'(f), 16'(c)};
    endfunction

    function automatic string fmt(input exp_t e);
        return $sformatf("sw=%b dp=%b wr=%0d rd=%0d rv=%b fc=%0d dc=%0d",
                         e.swap, e.drop, e.wr, e.rd, e.rv, e.fc, e.dc);
    endfunction

    task automatic cmp(input string nm, input int k, input exp_t a, input exp_t e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s u%0d: got %s, want %s", nm, k, fmt(a), fmt(e));
        end
    endtask

    // monitor: pops expected pulses whenever a DUT pulses, and expected snapshots on probe
    always @(negedge p_clk) begin
        for (int k = 0; k < 3; k++) begin
            if (act[k].swap | act[k].drop) begin
                if (pq[k].size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL pulse u%0d: got unexpected %s, want no pulse", k, fmt(act[k]));
                end else begin
                    cmp("pulse", k, act[k], pq[k].pop_front());
                end
            end
        end
        if (probe && sk.size() != 0) begin
            automatic int k = sk.pop_front();
            cmp("state", k, act[k], se.pop_front());
        end
        if (fin) begin
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (pq[k].size() != 0) begin
                    miscompares++;
                    $display("FAIL missing_pulse u%0d: got %0d pulses outstanding, want 0", k, pq[k].size());
                end
            end
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge p_clk);
            #2;
        end
    endtask

    task automatic expect_state(input int k, input exp_t e);
        sk.push_back(k);
        se.push_back(e);
        probe = 1'b1;
        cyc();
        probe = 1'b0;
    endtask

    initial begin
        // reset and idle
        cyc(3);
        srst_p = 1'b0;
        for (int k = 0; k < 3; k++) expect_state(k, mk(0, 0, 0, 0, 0, 0, 0));
        rd_done[0] = 1'b1;
        cyc();
        rd_done[0] = 1'b0;
        expect_state(0, mk(0, 0, 0, 0, 0, 0, 0));

        // disabled frame ends are ignored, enabling with eof high makes no edge
        enable[0] = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            eof[0] = ~eof[0];
            cyc();
        end
        enable[0] = 1'b1;
        cyc(5);
        expect_state(0, mk(0, 0, 0, 0, 0, 0, 0));

        // single swap on rising edge, held eof gives nothing more
        eof[0] = 1'b0;
        cyc(9);
        eof[0] = 1'b1;
        pq[0].push_back(mk(1, 0, 1, 0, 1, 1, 0));
        cyc(50);
        expect_state(0, mk(0, 0, 1, 0, 1, 1, 0));

        // swap and release together while full
        eof[0] = 1'b0;
        cyc();
        eof[0] = 1'b1;
        rd_done[0] = 1'b1;
        pq[0].push_back(mk(1, 0, 0, 1, 1, 2, 0));
        cyc();
        rd_done[0] = 1'b0;
        cyc();

        // full without release drops, then release empties the ring
        eof[0] = 1'b0;
        cyc();
        eof[0] = 1'b1;
        pq[0].push_back(mk(0, 1, 0, 1, 1, 3, 1));
        cyc(2);
        rd_done[0] = 1'b1;
        cyc();
        rd_done[0] = 1'b0;
        expect_state(0, mk(0, 0, 0, 0, 0, 3, 1));

        // three-buffer overrun, release, then wr_sel wraps
        eof[1] = 1'b1; pq[1].push_back(mk(1, 0, 1, 0, 1, 1, 0)); cyc(); eof[1] = 1'b0; cyc();
        eof[1] = 1'b1; pq[1].push_back(mk(1, 0, 2, 0, 1, 2, 0)); cyc(); eof[1] = 1'b0; cyc();
        eof[1] = 1'b1; pq[1].push_back(mk(0, 1, 2, 0, 1, 3, 1)); cyc(); eof[1] = 1'b0; cyc();
        rd_done[1] = 1'b1;
        cyc();
        rd_done[1] = 1'b0;
        expect_state(1, mk(0, 0, 2, 1, 1, 3, 1));
        eof[1] = 1'b1; pq[1].push_back(mk(1, 0, 0, 1, 1, 4, 1)); cyc(); eof[1] = 1'b0; cyc(2);

        // falling-edge mode with decimation by 3
        for (int i = 1; i <= 7; i++) begin
            eof[2] = 1'b1;
            cyc();
            eof[2] = 1'b0;
            if (i % 3 == 0) pq[2].push_back(mk(1, 0, i / 3, 0, 1, i, 0));
            cyc();
        end
        cyc();
        expect_state(2, mk(0, 0, 2, 0, 1, 7, 0));

        cyc(3);
        fin = 1'b1;
        cyc(3);
        $display("FAIL summary: got no end of run, want summary");
        $fatal(1);
    end

endmodule
